// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the saturating up-counter
package counter_pkg;

    localparam int DEFAULT_N = 6;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        FULL  = 2'd1
    } cnt_state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered 0->1 edge detector
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/adder_counter.sv
// rtl/adder_counter.sv - saturating up-counter with runtime ceiling and sticky overflow
import counter_pkg::*;

module adder_counter #(
    parameter int N         = DEFAULT_N,
    parameter int EDGE_MODE = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic [N-1:0] init_value,
    input  logic [N-1:0] max_value,
    input  logic         clr_ovf,
    output logic [N-1:0] count,
    output logic         full,
    output logic         ovf,
    output logic [1:0]   state_o
);

    cnt_state_t   state;
    cnt_state_t   state_next;
    logic [N-1:0] count_next;
    logic         ovf_next;
    logic [N-1:0] load_count;
    cnt_state_t   load_state;
    logic         accept;

    generate
        if (EDGE_MODE == 1) begin : g_edge
            rise_detect u_rise_detect (
                .clk   (clk),
                .reset (reset),
                .d     (inc),
                .rise  (accept)
            );
        end else begin : g_level
            assign accept = inc;
        end
    endgenerate

    always_comb begin
        load_count = (init_value > max_value) ? max_value : init_value;
        load_state = (load_count == max_value) ? FULL : COUNT;

        state_next = state;
        count_next = count;
        // a request seen in FULL always sets ovf, even alongside clr_ovf
        ovf_next   = (state == FULL && accept) ? 1'b1 : (clr_ovf ? 1'b0 : ovf);

        if (count > max_value) begin
            count_next = max_value;
            state_next = FULL;
        end else begin
            case (state)
                COUNT: begin
                    if (count == max_value) begin
                        state_next = FULL;
                    end else if (accept) begin
                        // count < max_value here, so the +1 can never wrap
                        count_next = count + 1'b1;
                        if (count + 1'b1 == max_value) begin
                            state_next = FULL;
                        end
                    end
                end
                FULL: begin
                    if (count < max_value) begin
                        state_next = COUNT;
                    end
                end
                default: begin
                    state_next = load_state;
                    count_next = load_count;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= load_state;
            count <= load_count;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

    assign full    = (state == FULL);
    assign state_o = state;

endmodule

// File: tb/tb_adder_counter.sv
// tb/tb_adder_counter.sv - table-driven self-checking bench for adder_counter
module tb_adder_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, inc0, clr0;
    logic [5:0] init0, max0;
    logic [5:0] count0;
    logic       full0, ovf0;
    logic [1:0] state0;

    logic       reset1, inc1, clr1;
    logic [5:0] init1, max1;
    logic [5:0] count1;
    logic       full1, ovf1;
    logic [1:0] state1;

    adder_counter #(.N(6), .EDGE_MODE(0)) dut0 (
        .clk        (clk),
        .reset      (reset0),
        .inc        (inc0),
        .init_value (init0),
        .max_value  (max0),
        .clr_ovf    (clr0),
        .count      (count0),
        .full       (full0),
        .ovf        (ovf0),
        .state_o    (state0)
    );

    adder_counter #(.N(6), .EDGE_MODE(1)) dut1 (
        .clk        (clk),
        .reset      (reset1),
        .inc        (inc1),
        .init_value (init1),
        .max_value  (max1),
        .clr_ovf    (clr1),
        .count      (count1),
        .full       (full1),
        .ovf        (ovf1),
        .state_o    (state1)
    );

    typedef struct {
        int         reps;
        logic       rst;
        logic       inc;
        logic       clr;
        logic [5:0] init;
        logic [5:0] maxv;
        logic [5:0] e_count;
        logic       e_full;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input int reps, input logic rst, input logic inc, input logic clr,
                       input logic [5:0] init, input logic [5:0] maxv,
                       input logic [5:0] e_count, input logic e_full, input logic e_ovf);
        vec_t v;
        v.reps = reps; v.rst = rst; v.inc = inc; v.clr = clr;
        v.init = init; v.maxv = maxv;
        v.e_count = e_count; v.e_full = e_full; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic tick1(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset0 = 1'b0; inc0 = 1'b0; clr0 = 1'b0; init0 = 6'd0; max0 = 6'd60;
        reset1 = 1'b0; inc1 = 1'b0; clr1 = 1'b0; init1 = 6'd3; max1 = 6'd60;

        //   reps rst inc clr init max  count full ovf
        add(1,  0, 0, 0, 0,  60, 0,  0, 0);   // reset load
        add(10, 1, 1, 0, 0,  60, 10, 0, 0);
        add(50, 1, 1, 0, 0,  60, 60, 1, 0);   // reaches ceiling
        add(5,  1, 1, 0, 0,  60, 60, 1, 1);   // held, ovf set
        add(1,  1, 0, 1, 0,  60, 60, 1, 0);   // clr_ovf
        add(1,  0, 0, 0, 60, 60, 60, 1, 0);   // reset straight into FULL
        add(1,  0, 0, 0, 63, 40, 40, 1, 0);   // init above ceiling clamps
        add(1,  1, 0, 0, 63, 63, 40, 0, 0);   // ceiling raised -> COUNT
        add(3,  1, 1, 0, 63, 63, 43, 0, 0);
        add(1,  1, 0, 0, 63, 43, 43, 1, 0);   // ceiling lowered onto count
        add(1,  1, 1, 1, 63, 43, 43, 1, 1);   // set beats clear
        add(1,  1, 0, 0, 63, 43, 43, 1, 1);   // sticky
        add(1,  1, 0, 1, 63, 43, 43, 1, 0);
        add(1,  0, 0, 0, 0,  60, 0,  0, 0);
        add(25, 1, 1, 0, 0,  60, 25, 0, 0);
        add(1,  0, 1, 0, 5,  60, 5,  0, 0);   // reset beats inc mid-count
        add(45, 1, 1, 0, 5,  60, 50, 0, 0);
        add(1,  1, 0, 0, 5,  20, 20, 1, 0);   // clamp to lowered ceiling
        add(3,  1, 1, 0, 5,  0,  0,  1, 1);   // max 0: pinned at 0
        add(1,  0, 0, 0, 0,  63, 0,  0, 0);
        add(63, 1, 1, 0, 0,  63, 63, 1, 0);   // full-scale ceiling, no wrap
        add(1,  1, 1, 0, 0,  63, 63, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset0 = vecs[i].rst;
            inc0   = vecs[i].inc;
            clr0   = vecs[i].clr;
            init0  = vecs[i].init;
            max0   = vecs[i].maxv;
            tick1(vecs[i].reps);
            check("count", i, 32'(count0), 32'(vecs[i].e_count));
            check("full",  i, 32'(full0),  32'(vecs[i].e_full));
            check("ovf",   i, 32'(ovf0),   32'(vecs[i].e_ovf));
            check("state", i, 32'(state0), vecs[i].e_full ? 32'd1 : 32'd0);
        end

        // edge mode: long high pulses count once each
        reset1 = 1'b0; inc1 = 1'b0;
        tick1(1);
        check("edge_reset_count", 0, 32'(count1), 32'd3);
        reset1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inc1 = 1'b1;
            tick1(1);
            check("edge_first", k, 32'(count1), 32'(4 + k));
            tick1(7);
            check("edge_held", k, 32'(count1), 32'(4 + k));
            inc1 = 1'b0;
            tick1(2);
        end
        check("edge_total", 0, 32'(count1), 32'd7);
        check("edge_ovf",   0, 32'(ovf1),   32'd0);

        // reset with inc held high: history cleared, so release counts once
        reset1 = 1'b0; inc1 = 1'b1;
        tick1(1);
        check("edge_rst_hi", 0, 32'(count1), 32'd3);
        reset1 = 1'b1;
        tick1(3);
        check("edge_after_rst", 0, 32'(count1), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
